// File: rtl/delta_event_aggregator_if.sv
// Single-cycle register port between the AXI4-Lite bridge and the delta event aggregator.
interface delta_event_aggregator_if;
    logic        REG_WE;
    logic        REG_RE;
    logic [7:0]  REG_ADDR;
    logic [31:0] REG_WDATA;
    logic [31:0] REG_RDATA;
    logic        REG_RVALID;

    modport master (
        output REG_WE, REG_RE, REG_ADDR, REG_WDATA,
        input  REG_RDATA, REG_RVALID
    );

    modport slave (
        input  REG_WE, REG_RE, REG_ADDR, REG_WDATA,
        output REG_RDATA, REG_RVALID
    );
endinterface

// File: rtl/delta_event_aggregator.sv
// Multi-channel change detector with sticky pending bits, first-event snapshots,
// saturating per-channel counters and one coalesced interrupt with hold-off.
module delta_event_aggregator #(
    parameter int NUM_CH        = 4,
    parameter int DATA_WIDTH    = 32,
    parameter int CNT_WIDTH     = 16,
    parameter int HOLDOFF_WIDTH = 8
) (
    input  logic                         ACLK,
    input  logic                         ARESET,
    input  logic [NUM_CH*DATA_WIDTH-1:0] CH_DATA,
    delta_event_aggregator_if.slave      reg_if,
    output logic                         IRQ
);
    logic [63:0]                           ts_q;
    logic [31:0]                           tshi_q;
    logic [NUM_CH*DATA_WIDTH-1:0]          sample_q;
    logic                                  prime_q;
    logic [NUM_CH-1:0]                     mask_q;
    logic [2*NUM_CH-1:0]                   mode_q;
    logic [HOLDOFF_WIDTH-1:0]              hold_q;
    logic [HOLDOFF_WIDTH-1:0]              hcnt_q;
    logic                                  irq_q;
    logic [31:0]                           rdata_q, rdata_d;
    logic                                  rvalid_q;

    logic [NUM_CH-1:0]                     pend_w;
    logic [NUM_CH-1:0][CNT_WIDTH-1:0]      cnt_w;
    logic [NUM_CH-1:0][DATA_WIDTH-1:0]     val_w;
    logic [NUM_CH-1:0][63:0]               snap_w;
    logic [NUM_CH-1:0]                     clr_w;
    logic [5:0]                            widx;
    logic                                  mp;
    logic                                  unused_bits;

    assign widx        = reg_if.REG_ADDR[7:2];
    assign clr_w       = (reg_if.REG_WE && widx == 6'h00) ? reg_if.REG_WDATA[NUM_CH-1:0] : '0;
    assign mp          = |(pend_w & mask_q);
    assign unused_bits = ^{reg_if.REG_WDATA, reg_if.REG_ADDR[1:0]};

    // Events are judged against the pre-write MODE because mode_q only moves on this edge.
    for (genvar c = 0; c < NUM_CH; c++) begin : g_lane
        delta_event_lane #(.DW(DATA_WIDTH), .CW(CNT_WIDTH)) u_lane (
            .clk_i    (ACLK),
            .rst_i    (ARESET),
            .prime_i  (prime_q),
            .mode_i   (mode_q[2*c +: 2]),
            .sample_i (sample_q[c*DATA_WIDTH +: DATA_WIDTH]),
            .data_i   (CH_DATA[c*DATA_WIDTH +: DATA_WIDTH]),
            .ts_i     (ts_q),
            .clr_i    (clr_w[c]),
            .pend_o   (pend_w[c]),
            .cnt_o    (cnt_w[c]),
            .val_o    (val_w[c]),
            .snap_o   (snap_w[c])
        );
    end

    always_comb begin
        rdata_d = '0;
        case (widx)
            6'h00:   rdata_d = 32'(pend_w);
            6'h01:   rdata_d = 32'(mask_q);
            6'h02:   rdata_d = 32'(mode_q);
            6'h03:   rdata_d = 32'(hold_q);
            6'h04:   rdata_d = ts_q[31:0];
            6'h05:   rdata_d = tshi_q;
            default: begin
                for (int c = 0; c < NUM_CH; c++) begin
                    if (reg_if.REG_ADDR[7:4] == 4'(c + 2)) begin
                        case (reg_if.REG_ADDR[3:2])
                            2'd0:    rdata_d = 32'(val_w[c]);
                            2'd1:    rdata_d = snap_w[c][31:0];
                            2'd2:    rdata_d = snap_w[c][63:32];
                            default: rdata_d = 32'(cnt_w[c]);
                        endcase
                    end
                end
            end
        endcase
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            ts_q     <= '0;
            tshi_q   <= '0;
            sample_q <= '0;
            prime_q  <= 1'b0;
            mask_q   <= '0;
            mode_q   <= '0;
            hold_q   <= '0;
            hcnt_q   <= '0;
            irq_q    <= 1'b0;
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
        end else begin
            ts_q     <= ts_q + 64'd1;
            sample_q <= CH_DATA;
            prime_q  <= 1'b1;
            rvalid_q <= reg_if.REG_RE;
            if (reg_if.REG_RE) begin
                rdata_q <= rdata_d;
                // Reading TS_LO freezes the upper half so the pair reads coherently.
                if (widx == 6'h04) tshi_q <= ts_q[63:32];
            end
            if (reg_if.REG_WE) begin
                case (widx)
                    6'h01:   mask_q <= reg_if.REG_WDATA[NUM_CH-1:0];
                    6'h02:   mode_q <= reg_if.REG_WDATA[2*NUM_CH-1:0];
                    6'h03:   hold_q <= reg_if.REG_WDATA[HOLDOFF_WIDTH-1:0];
                    default: ;
                endcase
            end
            irq_q <= mp && (hcnt_q >= hold_q);
            if (!mp)          hcnt_q <= '0;
            else if (!(&hcnt_q)) hcnt_q <= hcnt_q + HOLDOFF_WIDTH'(1);
        end
    end

    assign IRQ               = irq_q;
    assign reg_if.REG_RDATA  = rdata_q;
    assign reg_if.REG_RVALID = rvalid_q;
endmodule

// Per-channel event detect plus sticky pending, snapshot and saturating counter.
module delta_event_lane #(
    parameter int DW = 32,
    parameter int CW = 16
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          prime_i,
    input  logic [1:0]    mode_i,
    input  logic [DW-1:0] sample_i,
    input  logic [DW-1:0] data_i,
    input  logic [63:0]   ts_i,
    input  logic          clr_i,
    output logic          pend_o,
    output logic [CW-1:0] cnt_o,
    output logic [DW-1:0] val_o,
    output logic [63:0]   snap_o
);
    logic          ev;
    logic          pend_q;
    logic [CW-1:0] cnt_q;
    logic [DW-1:0] val_q;
    logic [63:0]   snap_q;

    always_comb begin
        ev = 1'b0;
        if (prime_i) begin
            case (mode_i)
                2'b00:   ev = (sample_i != data_i);
                2'b01:   ev = !sample_i[0] && data_i[0];
                2'b10:   ev = sample_i[0] && !data_i[0];
                default: ev = 1'b0;
            endcase
        end
    end

    // An event coinciding with a W1C wins and restarts the channel as a fresh first event.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pend_q <= 1'b0;
            cnt_q  <= '0;
            val_q  <= '0;
            snap_q <= '0;
        end else if (ev) begin
            pend_q <= 1'b1;
            if (!pend_q || clr_i) begin
                val_q  <= data_i;
                snap_q <= ts_i;
            end
            if (clr_i)          cnt_q <= CW'(1);
            else if (!(&cnt_q)) cnt_q <= cnt_q + CW'(1);
        end else if (clr_i) begin
            pend_q <= 1'b0;
            cnt_q  <= '0;
        end
    end

    assign pend_o = pend_q;
    assign cnt_o  = cnt_q;
    assign val_o  = val_q;
    assign snap_o = snap_q;
endmodule

// File: tb/tb_delta_event_aggregator.sv
// Directed plus randomized bench for delta_event_aggregator against a cycle-level reference model.
module tb_delta_event_aggregator;
    localparam int NC   = 4;
    localparam int DW   = 32;
    localparam int CW   = 4;
    localparam int HW   = 8;
    localparam int CMAX = (1 << CW) - 1;

    logic             ACLK = 1'b0;
    logic             ARESET;
    logic [NC*DW-1:0] CH_DATA;
    logic             IRQ;
    delta_event_aggregator_if rif();

    delta_event_aggregator #(.NUM_CH(NC), .DATA_WIDTH(DW), .CNT_WIDTH(CW), .HOLDOFF_WIDTH(HW)) dut (
        .ACLK    (ACLK),
        .ARESET  (ARESET),
        .CH_DATA (CH_DATA),
        .reg_if  (rif),
        .IRQ     (IRQ)
    );

    always #5 ACLK = ~ACLK;

    int checks = 0;
    int errors = 0;

    // Reference model state
    bit          m_pend [NC];
    int          m_cnt  [NC];
    logic [31:0] m_val  [NC];
    logic [63:0] m_snap [NC];
    logic [31:0] m_prev [NC];
    bit          m_prime;
    logic [63:0] m_ts;
    logic [3:0]  m_mask;
    logic [7:0]  m_mode;
    logic [7:0]  m_hold;
    int          m_run;
    bit          m_irq;
    logic [31:0] m_tshi;
    logic [31:0] m_rdata;
    bit          m_rvalid;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic m_reset();
        for (int c = 0; c < NC; c++) begin
            m_pend[c] = 0; m_cnt[c] = 0; m_val[c] = '0; m_snap[c] = '0; m_prev[c] = '0;
        end
        m_prime = 0; m_ts = '0; m_mask = '0; m_mode = '0; m_hold = '0;
        m_run = 0; m_irq = 0; m_tshi = '0; m_rdata = '0; m_rvalid = 0;
    endtask

    function automatic logic [31:0] m_reg(input logic [7:0] a);
        logic [31:0] r;
        int c, off;
        r = '0;
        if (a == 8'h00) begin
            for (int i = 0; i < NC; i++) r[i] = m_pend[i];
        end
        else if (a == 8'h04) r = {28'd0, m_mask};
        else if (a == 8'h08) r = {24'd0, m_mode};
        else if (a == 8'h0C) r = {24'd0, m_hold};
        else if (a == 8'h10) r = m_ts[31:0];
        else if (a == 8'h14) r = m_tshi;
        else if (a >= 8'h20 && int'(a) < 8'h20 + 16 * NC) begin
            c   = (int'(a) - 32) / 16;
            off = (int'(a) - 32) % 16;
            if (off == 0)      r = m_val[c];
            else if (off == 4) r = m_snap[c][31:0];
            else if (off == 8) r = m_snap[c][63:32];
            else               r = m_cnt[c];
        end
        return r;
    endfunction

    // Advance the model by one clock edge using the inputs currently applied.
    task automatic model_edge();
        logic [7:0]  a;
        logic [31:0] d;
        logic [3:0]  clr;
        logic [1:0]  md;
        bit          mp, ev;
        a  = rif.REG_ADDR;
        mp = 0;
        for (int c = 0; c < NC; c++) if (m_pend[c] && m_mask[c]) mp = 1;
        if (rif.REG_RE) begin
            m_rdata = m_reg(a);
            if (a == 8'h10) m_tshi = m_ts[63:32];
        end
        m_rvalid = rif.REG_RE;
        clr = (rif.REG_WE && a == 8'h00) ? rif.REG_WDATA[3:0] : 4'd0;
        for (int c = 0; c < NC; c++) begin
            d  = CH_DATA[c*DW +: DW];
            md = m_mode[2*c +: 2];
            case (md)
                2'd0:    ev = (d != m_prev[c]);
                2'd1:    ev = !m_prev[c][0] && d[0];
                2'd2:    ev = m_prev[c][0] && !d[0];
                default: ev = 0;
            endcase
            ev = ev && m_prime;
            if (ev) begin
                if (clr[c] || !m_pend[c]) begin m_val[c] = d; m_snap[c] = m_ts; end
                m_cnt[c]  = clr[c] ? 1 : (m_cnt[c] < CMAX ? m_cnt[c] + 1 : CMAX);
                m_pend[c] = 1;
            end else if (clr[c]) begin
                m_pend[c] = 0;
                m_cnt[c]  = 0;
            end
            m_prev[c] = d;
        end
        m_irq = mp && (m_run >= int'(m_hold));
        m_run = mp ? m_run + 1 : 0;
        if (rif.REG_WE) begin
            if (a == 8'h04) m_mask = rif.REG_WDATA[3:0];
            if (a == 8'h08) m_mode = rif.REG_WDATA[7:0];
            if (a == 8'h0C) m_hold = rif.REG_WDATA[7:0];
        end
        m_ts    = m_ts + 64'd1;
        m_prime = 1;
    endtask

    task automatic tick();
        model_edge();
        @(posedge ACLK);
        #1;
        chk("irq", IRQ, m_irq);
        chk("rvalid", rif.REG_RVALID, m_rvalid);
        chk("rdata", rif.REG_RDATA, m_rdata);
    endtask

    task automatic wr(input logic [7:0] a, input logic [31:0] d);
        rif.REG_WE = 1; rif.REG_ADDR = a; rif.REG_WDATA = d;
        tick();
        rif.REG_WE = 0;
    endtask

    task automatic rd(input logic [7:0] a, output logic [31:0] v);
        rif.REG_RE = 1; rif.REG_ADDR = a;
        tick();
        rif.REG_RE = 0;
        v = rif.REG_RDATA;
    endtask

    task automatic set_ch(input int c, input logic [31:0] v);
        CH_DATA[c*DW +: DW] = v;
    endtask

    initial begin
        logic [31:0] v, lo, hi;
        logic [63:0] t, tsx;
        int          n, r, c;

        ARESET = 1; CH_DATA = '0; set_ch(0, 32'h5A);
        rif.REG_WE = 0; rif.REG_RE = 0; rif.REG_ADDR = '0; rif.REG_WDATA = '0;
        m_reset();
        repeat (3) @(posedge ACLK);
        #1;
        chk("rst_irq", IRQ, 0);
        chk("rst_rdata", rif.REG_RDATA, 0);
        chk("rst_rvalid", rif.REG_RVALID, 0);
        ARESET = 0;

        // Constant input after release: the first sample must not look like a change.
        repeat (20) tick();
        for (int a = 0; a <= 8'h14; a += 4) begin
            rd(8'(a), v);
            if (a == 8'h10) chk("ts_lo_nonzero", v != 0, 1);
            else            chk("idle_reg_zero", v, 0);
        end

        // First event on channel 0 with immediate interrupt
        wr(8'h04, 1); wr(8'h08, 0); wr(8'h0C, 0);
        t = m_ts;
        set_ch(0, 32'h5B);
        tick();
        chk("irq_same_cycle", IRQ, 0);
        tick();
        chk("irq_rise", IRQ, 1);
        rd(8'h00, v); chk("pending0", v, 1);
        rd(8'h20, v); chk("value0", v, 32'h5B);
        rd(8'h24, v); chk("tsl0", v, t[31:0]);
        rd(8'h2C, v); chk("count0_1", v, 1);

        // Further events count but keep the first snapshot
        set_ch(0, 32'h5C); tick();
        set_ch(0, 32'h5D); tick();
        set_ch(0, 32'h5E); tick();
        rd(8'h2C, v); chk("count0_4", v, 4);
        rd(8'h20, v); chk("value0_held", v, 32'h5B);
        rd(8'h24, v); chk("tsl0_held", v, t[31:0]);
        wr(8'h00, 1);
        tick();
        chk("irq_fall", IRQ, 0);
        rd(8'h00, v); chk("pending_cleared", v, 0);
        rd(8'h2C, v); chk("count0_cleared", v, 0);

        // Rising-edge mode with hold-off 5
        wr(8'h08, 32'h0C);
        set_ch(1, 1); tick();
        wr(8'h08, 32'h04); wr(8'h04, 2); wr(8'h0C, 5);
        set_ch(1, 0); tick();
        rd(8'h00, v); chk("falling_ignored", v, 0);
        set_ch(1, 1); tick();
        n = 0;
        while (n < 20 && IRQ !== 1'b1) begin tick(); n++; end
        chk("irq_holdoff_latency", n, 6);
        wr(8'h00, 2); tick();
        set_ch(1, 0); tick();
        set_ch(1, 1); tick();
        repeat (3) tick();
        wr(8'h00, 2);
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("irq_suppressed", IRQ, 0);
        end

        // W1C colliding with an event, then counter saturation
        wr(8'h04, 1); wr(8'h0C, 0);
        set_ch(0, 32'h60); tick();
        set_ch(0, 32'h61);
        rif.REG_WE = 1; rif.REG_ADDR = 8'h00; rif.REG_WDATA = 1;
        tick();
        rif.REG_WE = 0;
        rd(8'h00, v); chk("w1c_set_wins", v[0], 1);
        rd(8'h2C, v); chk("w1c_count_1", v, 1);
        for (int i = 0; i < 20; i++) begin
            set_ch(0, CH_DATA[31:0] ^ 32'h1); tick();
        end
        rd(8'h2C, v); chk("count_saturated", v, CMAX);

        // Coherent timestamp pair
        tsx = m_ts;
        rd(8'h10, lo);
        rd(8'h14, hi);
        chk("ts_pair", {hi, lo}, tsx);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            r = $urandom_range(0, 9);
            c = $urandom_range(0, NC - 1);
            if (r <= 3) begin
                if ($urandom_range(0, 1) != 0) set_ch(c, CH_DATA[c*DW +: DW] ^ 32'h1);
                else                           set_ch(c, $urandom);
                tick();
            end else if (r == 4) begin
                if ($urandom_range(0, 1) != 0) set_ch(c, $urandom);
                case ($urandom_range(0, 3))
                    0: wr(8'h00, $urandom);
                    1: wr(8'h04, $urandom);
                    2: wr(8'h08, $urandom);
                    default: wr(8'h0C, $urandom_range(0, 6));
                endcase
            end else if (r == 5) begin
                wr(8'({$urandom_range(4, 27), 2'b00}), $urandom);
            end else if (r <= 8) begin
                rd(8'({$urandom_range(0, 27), 2'b00}), v);
            end else begin
                rif.REG_WE = 1; rif.REG_RE = 1;
                rif.REG_ADDR = 8'({$urandom_range(1, 3), 2'b00});
                rif.REG_WDATA = $urandom_range(0, 6);
                tick();
                rif.REG_WE = 0; rif.REG_RE = 0;
            end
        end

        // Asynchronous reset while the interrupt is active
        wr(8'h08, 0); wr(8'h0C, 0); wr(8'h04, 32'hF); wr(8'h00, 32'hF);
        set_ch(0, CH_DATA[31:0] ^ 32'h1); tick();
        tick();
        chk("irq_before_reset", IRQ, 1);
        rd(8'h20, v);
        #3 ARESET = 1;
        #1;
        chk("async_irq", IRQ, 0);
        chk("async_rdata", rif.REG_RDATA, 0);
        chk("async_rvalid", rif.REG_RVALID, 0);
        m_reset();
        @(posedge ACLK);
        #1 ARESET = 0;
        set_ch(2, 32'hDEAD_BEEF);
        repeat (3) tick();
        rd(8'h00, v); chk("no_stale_event", v, 0);
        for (int a = 8'h04; a < 8'h60; a += 4) rd(8'(a), v);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/delta_event_aggregator.md
Name: delta_event_aggregator

Overview:
- Multi-channel successor to the single-bit delta status register in the register pool.
- Watches NUM_CH status words, detects per-channel change events (selectable mode), and latches sticky pending bits with first-event value/timestamp snapshots and saturating event counters.
- Drives one coalesced interrupt with programmable hold-off.
- Sits between the pool's hwif bundle and the core; software accesses it through a simple single-cycle register port bridged from AXI4-Lite.

Parameters:
- NUM_CH, 4, number of monitored channels (1..8)
- DATA_WIDTH, 32, width of each channel status word (1..32)
- CNT_WIDTH, 16, width of per-channel saturating event counter (1..32)
- HOLDOFF_WIDTH, 8, width of IRQ hold-off register (1..16)

Ports:
- ACLK  in  1  clock
- ARESET  in  1  reset. Asynchronous, active-high.
- CH_DATA  in  NUM_CH*DATA_WIDTH  status words; channel c occupies bits [c*DATA_WIDTH +: DATA_WIDTH]
- REG_WE  in  1  write strobe, one-cycle pulse
- REG_RE  in  1  read strobe, one-cycle pulse
- REG_ADDR  in  8  byte address, word aligned
- REG_WDATA  in  32  write data
- REG_RDATA  out  32  read data
- REG_RVALID  out  1  read data valid, one-cycle pulse
- IRQ  out  1  coalesced interrupt, level, registered

Behaviour:
- Reset values (async assert, sync release): all registers 0; sample_q 0; prime 0; IRQ 0; REG_RDATA 0; REG_RVALID 0; TS 0.
- TS: 64-bit free-running counter, +1 per cycle, wraps 2^64-1 -> 0.
- Sampling: sample_q <= CH_DATA every cycle.
  - prime sets 1 on the first cycle after reset release.
  - No events are generated while prime==0.
- Event for channel c, combinational on (sample_q, CH_DATA), selected by MODE[2c+1:2c]:
  - 00: any bit changed
  - 01: bit0 rising
  - 10: bit0 falling
  - 11: disabled
- On the edge where event_c is true:
  - PENDING[c] <= 1.
  - COUNT_c <= COUNT_c+1, saturating at all-ones.
  - If PENDING[c] was 0: VALUE_c <= CH_DATA_c and TSL_c/TSH_c <= TS (first-event snapshot).
  - If PENDING[c] was already 1, snapshots are held.
- Register map (unmapped addresses read 0; writes to RO or unmapped are ignored; widths narrower than 32 are zero-extended):
  - 0x00 PENDING, W1C. Clearing bit c also zeroes COUNT_c.
  - 0x04 MASK, RW, NUM_CH bits.
  - 0x08 MODE, RW, 2*NUM_CH bits.
  - 0x0C HOLDOFF, RW.
  - 0x10 TS_LO, RO. A read latches TS[63:32] into the TS_HI shadow in the same cycle.
  - 0x14 TS_HI, RO shadow.
  - 0x20+0x10*c: +0 VALUE_c, +4 TSL_c, +8 TSH_c, +C COUNT_c, all RO.
- Write latency: register updated on the REG_WE edge.
- Read latency: 1 cycle. REG_RDATA/REG_RVALID are registered on the REG_RE edge. REG_RDATA holds its value until the next read.
- Simultaneous events:
  - W1C of bit c and event_c in the same cycle: set wins. PENDING[c]=1, COUNT_c=1, snapshots re-captured.
  - REG_WE and REG_RE in the same cycle: write is applied; read returns the pre-write value.
  - MODE write and event in the same cycle: the event uses the old MODE.
- IRQ:
  - mp = |(PENDING & MASK).
  - hcnt resets to 0 while mp==0; increments (saturating) while mp==1.
  - IRQ <= mp && (hcnt >= HOLDOFF).
  - With HOLDOFF=0, IRQ rises 1 cycle after mp rises; in general HOLDOFF+1 cycles after.
  - IRQ falls 1 cycle after mp falls.
- Reset mid-operation: all state clears immediately; prime is re-armed so no spurious event from stale sample_q.

Test Plan:
- Reset release with CH_DATA[0]=0x5A constant -> PENDING=0 after 20 cycles; no event on first sample; IRQ=0; all reads of 0x00..0x14 return 0 except TS_LO nonzero.
- MODE=0, MASK=0x1, HOLDOFF=0; CH0 0x5A->0x5B at TS=T -> PENDING=0x1; VALUE_0=0x5B; TSL_0=T; COUNT_0=1; IRQ high 1 cycle after PENDING.
- Three further CH0 changes -> COUNT_0=4; VALUE_0 still 0x5B; TSL_0 still T. Write 0x1 to 0x00 -> PENDING=0, COUNT_0=0, IRQ low next cycle.
- MODE ch1=01, MASK=0x2, HOLDOFF=5; ch1 bit0 falling -> no event. Then rising -> PENDING[1]=1; IRQ rises exactly 6 cycles later. Clear after 3 cycles -> IRQ never asserts.
- W1C of bit0 in the same cycle as a CH0 event -> PENDING[0]=1, COUNT_0=1. With CNT_WIDTH=4, drive 20 events -> COUNT_0=0xF.
- Read TS_LO then TS_HI while TS crosses 0x0000_0000_FFFF_FFFF -> the {TS_HI,TS_LO} pair is coherent. Assert ARESET mid-run -> IRQ=0 and all registers 0 asynchronously.
